// File: rtl/key_speed_sel.sv
// Debounced push-button that steps a speed index on each accepted press and
// derives the matching LED flash period from it.
module key_speed_sel #(
  parameter int DB_CYCLES   = 1_000_000,
  parameter int IDX_MAX     = 8,
  parameter int BASE_PERIOD = 100_000_000,
  parameter int STEP_PERIOD = 50_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_in,
  output logic        key_level,
  output logic        key_pulse,
  output logic [3:0]  speed_idx,
  output logic [28:0] period
);

  localparam int               CNT_W    = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [3:0]       IDX_LAST = 4'(IDX_MAX);
  localparam logic [28:0]      BASE_P   = 29'(BASE_PERIOD);
  localparam logic [28:0]      STEP_P   = 29'(STEP_PERIOD);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DB_DOWN = 2'd1,
    DOWN    = 2'd2,
    DB_UP   = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             key_meta;
  logic             key_s;

  // Both flops come out of reset at the released level so that reset
  // deassertion never looks like a falling edge on the key.
  // NOTE: sequential state is always written with <=; blocking assignments
  // here would make the second flop see the new first-flop value and collapse
  // the synchronizer to a single stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_meta <= 1'b1;
      key_s    <= 1'b1;
    end else begin
      key_meta <= key_in;
      key_s    <= key_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      key_level <= 1'b1;
      key_pulse <= 1'b0;
      speed_idx <= 4'd0;
    end else begin
      key_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (!key_s) begin
            state <= DB_DOWN;
            cnt   <= '0;
          end
        end

        DB_DOWN: begin
          if (key_s) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            // Press accepted: the only place that strobes and steps the index.
            state     <= DOWN;
            cnt       <= '0;
            key_level <= 1'b0;
            key_pulse <= 1'b1;
            speed_idx <= (speed_idx == IDX_LAST) ? 4'd0 : speed_idx + 4'd1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DOWN: begin
          if (key_s) begin
            state <= DB_UP;
            cnt   <= '0;
          end
        end

        DB_UP: begin
          if (!key_s) begin
            state <= DOWN;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state     <= IDLE;
            cnt       <= '0;
            key_level <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Period is combinational from the index register, so it tracks speed_idx
  // in the same cycle and shows BASE_PERIOD while reset holds the index at 0.
  assign period = BASE_P + STEP_P * {25'd0, speed_idx};

endmodule

// File: tb/tb_key_speed_sel.sv
// Self-checking bench for key_speed_sel: directed scenarios plus random key
// activity, all compared against a run-length model of the debouncer.
module tb_key_speed_sel;

  localparam int     DB      = 4;
  localparam int     IDX_MAX = 8;
  localparam longint BASE    = 100_000_000;
  localparam longint STEP    = 50_000_000;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b0;
  logic        key_in = 1'b1;
  logic        key_level;
  logic        key_pulse;
  logic [3:0]  speed_idx;
  logic [28:0] period;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  key_speed_sel #(
    .DB_CYCLES (DB),
    .IDX_MAX   (IDX_MAX)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_in    (key_in),
    .key_level (key_level),
    .key_pulse (key_pulse),
    .speed_idx (speed_idx),
    .period    (period)
  );

  // Reference model: the key value seen by the debouncer lags key_in by two
  // edges; a level change is accepted once DB+1 consecutive observations
  // disagree with the current level.
  bit m_s1      = 1'b1;
  bit m_s2      = 1'b1;
  bit m_obs     = 1'b1;
  bit m_run_val = 1'b1;
  int m_run_len = DB + 2;
  bit m_level   = 1'b1;
  bit m_pulse   = 1'b0;
  int m_idx     = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_s1 = 1'b1; m_s2 = 1'b1; m_run_val = 1'b1; m_run_len = DB + 2;
      m_level = 1'b1; m_pulse = 1'b0; m_idx = 0;
    end else begin
      m_obs = m_s2;
      m_s2  = m_s1;
      m_s1  = key_in;
      if (m_obs == m_run_val) begin
        if (m_run_len < 1000) m_run_len++;
      end else begin
        m_run_val = m_obs;
        m_run_len = 1;
      end
      m_pulse = 1'b0;
      if (m_run_len == DB + 1) begin
        if (m_run_val == 1'b0 && m_level) begin
          m_level = 1'b0;
          m_pulse = 1'b1;
          m_idx   = (m_idx + 1) % (IDX_MAX + 1);
        end else if (m_run_val == 1'b1 && !m_level) begin
          m_level = 1'b1;
        end
      end
    end
  end

  function automatic logic [34:0] exp_vec();
    longint p;
    p = BASE + STEP * longint'(m_idx);
    return {m_pulse, m_level, 4'(m_idx), 29'(p)};
  endfunction

  localparam logic [34:0] RESET_VEC = {1'b0, 1'b1, 4'd0, 29'(BASE)};

  task automatic test_reset();
    int pulses = 0;
    rst_n  = 1'b0;
    key_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({key_pulse, key_level, speed_idx, period} !== RESET_VEC)
        $display("FAIL reset_hold cyc=%0d got=%h exp=%h", i,
                 {key_pulse, key_level, speed_idx, period}, RESET_VEC);
      if ({key_pulse, key_level, speed_idx, period} !== RESET_VEC) errors++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      pulses += int'(key_pulse);
      checks++;
      if ({key_pulse, key_level, speed_idx, period} !== exp_vec()) begin
        errors++;
        $display("FAIL idle_high cyc=%0d got=%h exp=%h", i,
                 {key_pulse, key_level, speed_idx, period}, exp_vec());
      end
    end
    checks++;
    if (pulses != 0 || period !== 29'(BASE) || key_level !== 1'b1) begin
      errors++;
      $display("FAIL idle_summary pulses=%0d period=%0d level=%0b exp 0/%0d/1",
               pulses, period, key_level, BASE);
    end
  endtask

  task automatic test_single_press();
    int pulses = 0;
    int pulse_at = -1;
    key_in = 1'b0;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      if (key_pulse === 1'b1) begin
        pulses++;
        if (pulse_at < 0) pulse_at = i;
      end
      checks++;
      if ({key_pulse, key_level, speed_idx, period} !== exp_vec()) begin
        errors++;
        $display("FAIL press_cycle cyc=%0d got=%h exp=%h", i,
                 {key_pulse, key_level, speed_idx, period}, exp_vec());
      end
    end
    // Edge 1 is the first edge sampling key_in=0; pulse lands on edge 1+6.
    checks++;
    if (pulses != 1 || pulse_at != 7) begin
      errors++;
      $display("FAIL press_latency pulses=%0d at_edge=%0d exp 1 at 7", pulses, pulse_at);
    end
    checks++;
    if (speed_idx !== 4'd1 || period !== 29'd150_000_000 || key_level !== 1'b0) begin
      errors++;
      $display("FAIL press_result idx=%0d period=%0d level=%0b exp 1/150000000/0",
               speed_idx, period, key_level);
    end
    key_in = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_bounce();
    int pulses = 0;
    logic [3:0] idx0;
    idx0 = speed_idx;
    for (int i = 0; i < 60; i++) begin
      key_in = (i < 40) ? ((i / 2) % 2 == 1) : 1'b1;
      @(negedge clk);
      pulses += int'(key_pulse);
      checks++;
      if ({key_pulse, key_level, speed_idx, period} !== exp_vec()) begin
        errors++;
        $display("FAIL bounce_cycle cyc=%0d got=%h exp=%h", i,
                 {key_pulse, key_level, speed_idx, period}, exp_vec());
      end
    end
    checks++;
    if (pulses != 0 || speed_idx !== idx0) begin
      errors++;
      $display("FAIL bounce_result pulses=%0d idx=%0d exp 0/%0d", pulses, speed_idx, idx0);
    end
  endtask

  task automatic test_wrap();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      for (int i = 0; i < 40; i++) begin
        key_in = (i >= 20);
        @(negedge clk);
        checks++;
        if ({key_pulse, key_level, speed_idx, period} !== exp_vec()) begin
          errors++;
          $display("FAIL wrap_cycle press=%0d cyc=%0d got=%h exp=%h", k, i,
                   {key_pulse, key_level, speed_idx, period}, exp_vec());
        end
      end
      checks++;
      if (speed_idx !== 4'(k % 9)) begin
        errors++;
        $display("FAIL wrap_idx press=%0d got=%0d exp=%0d", k, speed_idx, k % 9);
      end
      if (k == 8) begin
        checks++;
        if (period !== 29'd500_000_000) begin
          errors++;
          $display("FAIL wrap_period_max got=%0d exp=500000000", period);
        end
      end
      if (k == 9) begin
        checks++;
        if (period !== 29'd100_000_000) begin
          errors++;
          $display("FAIL wrap_period_zero got=%0d exp=100000000", period);
        end
      end
    end
  endtask

  task automatic test_glitch();
    int pulses = 0;
    int level_high = 0;
    for (int i = 0; i < 41; i++) begin
      key_in = (i == 20);
      @(negedge clk);
      pulses += int'(key_pulse);
      if (i >= 10 && key_level !== 1'b0) level_high++;
      checks++;
      if ({key_pulse, key_level, speed_idx, period} !== exp_vec()) begin
        errors++;
        $display("FAIL glitch_cycle cyc=%0d got=%h exp=%h", i,
                 {key_pulse, key_level, speed_idx, period}, exp_vec());
      end
    end
    checks++;
    if (pulses != 1 || level_high != 0) begin
      errors++;
      $display("FAIL glitch_result pulses=%0d level_high_cycles=%0d exp 1/0", pulses, level_high);
    end
    key_in = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_reset_mid_debounce();
    int pulses = 0;
    int pulse_at = -1;
    key_in = 1'b0;
    // Edges 1..5: sync, sync, enter DB_DOWN, then two counting cycles.
    repeat (5) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({key_pulse, key_level, speed_idx, period} !== RESET_VEC) begin
      errors++;
      $display("FAIL async_reset got=%h exp=%h",
               {key_pulse, key_level, speed_idx, period}, RESET_VEC);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      if (key_pulse === 1'b1) begin
        pulses++;
        if (pulse_at < 0) pulse_at = i;
      end
      checks++;
      if ({key_pulse, key_level, speed_idx, period} !== exp_vec()) begin
        errors++;
        $display("FAIL post_reset_cycle cyc=%0d got=%h exp=%h", i,
                 {key_pulse, key_level, speed_idx, period}, exp_vec());
      end
    end
    checks++;
    if (pulses != 1 || pulse_at != 7 || speed_idx !== 4'd1) begin
      errors++;
      $display("FAIL post_reset_press pulses=%0d at_edge=%0d idx=%0d exp 1 at 7 idx 1",
               pulses, pulse_at, speed_idx);
    end
    key_in = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_random();
    int run_left = 0;
    for (int i = 0; i < 3000; i++) begin
      if (run_left == 0) begin
        key_in   = 1'($urandom_range(0, 1));
        run_left = int'($urandom_range(1, 12));
      end
      run_left--;
      @(negedge clk);
      checks++;
      if ({key_pulse, key_level, speed_idx, period} !== exp_vec()) begin
        errors++;
        $display("FAIL random_cycle cyc=%0d got=%h exp=%h", i,
                 {key_pulse, key_level, speed_idx, period}, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_wrap();
    test_glitch();
    test_reset_mid_debounce();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
